mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single data-cache port (memread/memwrite strobes, clk_stall busy flag) between the instruction-fetch requester (I) and the load/store requester (D).
- Round-robin arbitration; one transaction in flight at a time.
- Issues each access as a one-cycle strobe, tracks the backend stall window, and returns read data with a one-cycle ack.
- Includes a watchdog so a hung backend cannot wedge the core.

Parameters:
- TIMEOUT, 64, max cycles allowed in each of WAIT_HI and WAIT_LO before abort
- CNT_W, 7, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- i_req  in  1  instruction read request, held until i_ack
- i_addr  in  32  fetch address, stable while i_req
- i_rdata  out  32  fetch data, valid in i_ack cycle, held until next i_ack
- i_ack  out  1  one-cycle completion pulse
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_sign_mask  in  4  [3] sign-extend, [2:0] 001 byte / 011 half / 111 word
- d_rdata  out  32  load data, valid in d_ack cycle, held until next d_ack
- d_ack  out  1  one-cycle completion pulse
- mem_addr  out  32  backend address, registered, stable from ISSUE through RESP
- mem_wdata  out  32  backend store data, registered
- mem_sign_mask  out  4  backend mask; I transactions always 4'b0111
- mem_memread  out  1  one-cycle read strobe
- mem_memwrite  out  1  one-cycle write strobe
- mem_rdata  in  32  backend read data, valid in first cycle mem_stall is low after being high
- mem_stall  in  1  backend busy (the cache's clk_stall)
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset values: all outputs 0, state IDLE, watchdog 0, rr_last = I (first tie goes to D).
- States:
  - IDLE: only when mem_stall==0 and a req is high, latch the winner's addr/wdata/mask/we and the grant id, then go to ISSUE. Tie rule: grant the port not equal to rr_last, then set rr_last = winner.
  - ISSUE: exactly one cycle. mem_memread (I, or D with we=0) or mem_memwrite (D with we=1) is high. Go to WAIT_HI.
  - WAIT_HI: on mem_stall==1 go to WAIT_LO. Otherwise the watchdog increments.
  - WAIT_LO: on mem_stall==0 capture mem_rdata into the granted port's rdata register (stores leave rdata unchanged) and go to RESP. Otherwise the watchdog increments.
  - RESP: the granted ack is high for one cycle. Go to IDLE.
- Watchdog:
  - Clears on entry to WAIT_HI and again on entry to WAIT_LO.
  - Reaching TIMEOUT in either wait state sets timeout_err (sticky until reset), loads rdata = 0 and goes to RESP, so the requester is still acked.
- Strobes are never high outside ISSUE. The backend resamples strobes every idle cycle, so a held strobe would duplicate the access.
- Latency: request first seen high in cycle 0 and backend stalls K cycles gives ack in cycle K+3. Next grant is possible in cycle K+4, so back-to-back requests are allowed.
- Requester contract: req drops in the cycle after ack unless a new request follows. Requester inputs are not used after latching.
- No preemption: a req rising mid-transaction waits for IDLE. Both ports never ack in the same cycle.
- Reset mid-transaction: returns to IDLE and drops all strobes/acks immediately. No new issue occurs until mem_stall is observed low, which lets the abandoned backend access finish.
- Store data and mask are passed through unmodified; no width arithmetic is done here.

Decomposition:
- Shared package mem_pkg:
  - state encodings IDLE/ISSUE/WAIT_HI/WAIT_LO/RESP
  - port-id constants PORT_I=0, PORT_D=1
  - sign-mask constants MASK_BYTE=3'b001, MASK_HALF=3'b011, MASK_WORD=3'b111
- One sub-module, rr_arb2: 2-way round-robin picker (req[1:0], last -> grant_id, grant_valid). Everything else is inline.

Test Plan:
- Single I read, backend model stalls K=3 and returns 32'hDEADBEEF: exactly one mem_memread pulse with mem_sign_mask=4'b0111; i_ack in cycle 6 with i_rdata=32'hDEADBEEF; d_ack never asserted.
- D byte store (d_addr=32'h104, d_wdata=32'h000000AB, d_sign_mask=4'b0001), K=2: one mem_memwrite pulse with mem_addr/mem_wdata/mem_sign_mask matching; d_ack in cycle 5; d_rdata unchanged.
- i_req and d_req both held high continuously from reset for 4 transactions: grant order D, I, D, I; strobes never overlap; each port acked twice.
- Backend never raises mem_stall: timeout_err rises after TIMEOUT cycles in WAIT_HI; ack pulses with rdata=0; the next request still completes normally with timeout_err remaining 1.
- reset pulsed during WAIT_LO while mem_stall stays high 5 more cycles: after reset all outputs are 0; no strobe until mem_stall low; a pending i_req is then issued and acked.
- Backend stall K=0 until TIMEOUT-1 then normal: timeout_err stays 0 (boundary is one cycle short of timeout).

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-cache port arbiter.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        RESP    = 3'd4
    } state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam logic [2:0] MASK_BYTE = 3'b001;
    localparam logic [2:0] MASK_HALF = 3'b011;
    localparam logic [2:0] MASK_WORD = 3'b111;

    // Instruction fetches are always unsigned full words.
    localparam logic [3:0] I_FETCH_MASK = {1'b0, MASK_WORD};

    function automatic logic is_store(input logic port, input logic we);
        return (port == PORT_D) && we;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the port that did not win last time is chosen.
module rr_arb2
    import mem_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       grant_id_o,
    output logic       grant_valid_o
);

    // Pick the winner; index 1 is the D port, index 0 the I port.
    always_comb begin
        grant_valid_o = req_i[1] | req_i[0];
        if (req_i == 2'b11) begin
            grant_id_o = ~last_i;
        end else if (req_i[1]) begin
            grant_id_o = PORT_D;
        end else begin
            grant_id_o = PORT_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-cache port between instruction fetch and load/store, one access
// in flight, with a watchdog that force-completes an access if the backend hangs.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_sign_mask,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_memread,
    output logic        mem_memwrite,
    input  logic [31:0] mem_rdata,
    input  logic        mem_stall,
    output logic        timeout_err
);

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q;
    logic              gnt_q;
    logic              we_q;
    logic              rr_last_q;
    logic [CNT_W-1:0]  wdog_q;
    logic [31:0]       i_rdata_q;
    logic [31:0]       d_rdata_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        mask_q;
    logic              i_ack_q;
    logic              d_ack_q;
    logic              rd_q;
    logic              wr_q;
    logic              terr_q;

    logic              pick_id_s;
    logic              pick_valid_s;
    logic              wait_done_s;
    logic              wdog_expired_s;
    logic [31:0]       resp_data_s;

    rr_arb2 u_rr_arb2 (
        .req_i         ({d_req, i_req}),
        .last_i        (rr_last_q),
        .grant_id_o    (pick_id_s),
        .grant_valid_o (pick_valid_s)
    );

    // Completion conditions of the two wait states, normal and watchdog abort.
    always_comb begin
        wait_done_s    = (state_q == WAIT_LO) && !mem_stall;
        wdog_expired_s = (wdog_q == WDOG_LAST) &&
                         (((state_q == WAIT_HI) && !mem_stall) ||
                          ((state_q == WAIT_LO) && mem_stall));
        if (wdog_expired_s) begin
            resp_data_s = 32'h0000_0000;
        end else begin
            resp_data_s = mem_rdata;
        end
    end

    // Transaction FSM with registered strobes, acks and read-data holding registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= PORT_I;
            we_q      <= 1'b0;
            rr_last_q <= PORT_I;
            wdog_q    <= '0;
            i_rdata_q <= 32'h0000_0000;
            d_rdata_q <= 32'h0000_0000;
            addr_q    <= 32'h0000_0000;
            wdata_q   <= 32'h0000_0000;
            mask_q    <= 4'h0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Holding off while stalled lets an access abandoned by reset drain.
                    if (!mem_stall && pick_valid_s) begin
                        gnt_q     <= pick_id_s;
                        rr_last_q <= pick_id_s;
                        if (pick_id_s == PORT_D) begin
                            addr_q  <= d_addr;
                            wdata_q <= d_wdata;
                            mask_q  <= d_sign_mask;
                            we_q    <= d_we;
                            wr_q    <= is_store(pick_id_s, d_we);
                            rd_q    <= !is_store(pick_id_s, d_we);
                        end else begin
                            addr_q  <= i_addr;
                            wdata_q <= 32'h0000_0000;
                            mask_q  <= I_FETCH_MASK;
                            we_q    <= 1'b0;
                            rd_q    <= 1'b1;
                        end
                        state_q <= ISSUE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    wdog_q  <= '0;
                    state_q <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (mem_stall) begin
                        wdog_q  <= '0;
                        state_q <= WAIT_LO;
                    end else begin
                        wdog_q  <= wdog_q + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (mem_stall) begin
                        wdog_q <= wdog_q + 1'b1;
                    end else begin
                        wdog_q <= wdog_q;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Normal completion and watchdog abort both end in RESP with an ack.
            if (wait_done_s || wdog_expired_s) begin
                state_q <= RESP;
                if (wdog_expired_s) begin
                    terr_q <= 1'b1;
                end
                if (gnt_q == PORT_D) begin
                    d_ack_q <= 1'b1;
                    if (wdog_expired_s || !we_q) begin
                        d_rdata_q <= resp_data_s;
                    end
                end else begin
                    i_ack_q   <= 1'b1;
                    i_rdata_q <= resp_data_s;
                end
            end
        end
    end

    assign i_rdata       = i_rdata_q;
    assign i_ack         = i_ack_q;
    assign d_rdata       = d_rdata_q;
    assign d_ack         = d_ack_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_sign_mask = mask_q;
    assign mem_memread   = rd_q;
    assign mem_memwrite  = wr_q;
    assign timeout_err   = terr_q;

endmodule
